// File: rtl/btn_event.sv
// Button gesture decoder: turns a debounced button level into short/long/repeat events.
// Latency: every pulse is registered and appears in the cycle after the sampling edge.
// Backpressure: none; the pulses are single-cycle strobes that are never held or queued.
//
// Ports:
//   clk          - system clock (rising edge)
//   rst_n        - asynchronous active-low reset
//   btn_level    - debounced button level, 1 = pressed, already synchronous to clk
//   short_pulse  - 1-cycle strobe on release of a press shorter than LONG_CNT cycles
//   long_pulse   - 1-cycle strobe when the hold reaches LONG_CNT cycles
//   repeat_pulse - 1-cycle strobe every REPEAT_CNT cycles after long_pulse while held
//   held         - level, 1 while a press is being tracked (PRESSED or LONG)
//   long_active  - level, 1 once the long threshold has been reached (LONG)
//
// Build option: define BTN_EVENT_REPEAT_EN to build the auto-repeat logic. Without it
// repeat_pulse is tied low and the FSM simply waits for release once in LONG.
module btn_event #(
    parameter int CNT_W      = 26,
    parameter int LONG_CNT   = 27_000_000,
    parameter int REPEAT_CNT = 6_750_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_level,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held,
    output logic long_active
);

    // Both thresholds must fit in the counter and leave room for at least one
    // counting cycle; otherwise the compare values below would be truncated.
    if (LONG_CNT < 2 || LONG_CNT >= (64'd1 << CNT_W)) begin : g_long_chk
        $error("btn_event: LONG_CNT out of range for CNT_W");
    end
    if (REPEAT_CNT < 2 || REPEAT_CNT >= (64'd1 << CNT_W)) begin : g_rep_chk
        $error("btn_event: REPEAT_CNT out of range for CNT_W");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    // Compare against N-1 because cnt is cleared on the edge that enters a state,
    // so the N-th edge after entry is the one that sees cnt == N-1.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               short_nxt;
    logic               long_nxt;

`ifdef BTN_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);
    logic               repeat_nxt;
    logic               repeat_q;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        short_nxt = 1'b0;
        long_nxt  = 1'b0;
`ifdef BTN_EVENT_REPEAT_EN
        repeat_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (btn_level) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end
            end
            PRESSED: begin
                // Release is checked first so a release on the threshold edge
                // still counts as a short press.
                if (!btn_level) begin
                    state_nxt = IDLE;
                    short_nxt = 1'b1;
                end else if (cnt == LONG_LAST) begin
                    state_nxt = LONG;
                    long_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            LONG: begin
                // Releasing a long press is silent: the long event already fired.
                if (!btn_level) begin
                    state_nxt = IDLE;
                end
`ifdef BTN_EVENT_REPEAT_EN
                else if (cnt == REPEAT_LAST) begin
                    repeat_nxt = 1'b1;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            short_pulse <= short_nxt;
            long_pulse  <= long_nxt;
        end
    end

`ifdef BTN_EVENT_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= repeat_nxt;
        end
    end
    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = 1'b0;
`endif

    assign held        = (state == PRESSED) || (state == LONG);
    assign long_active = (state == LONG);

endmodule

// File: tb/tb_btn_event.sv
// Directed bench for btn_event with LONG_CNT=10, REPEAT_CNT=4.
// Outputs are compared as one vector {short, long, repeat, held, long_active}.
module tb_btn_event;

    localparam int CNT_W      = 26;
    localparam int LONG_CNT   = 10;
    localparam int REPEAT_CNT = 4;
`ifdef BTN_EVENT_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic btn_level;
    logic short_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic held;
    logic long_active;
    logic [4:0] obs;

    int checks;
    int failures;

    btn_event #(
        .CNT_W      (CNT_W),
        .LONG_CNT   (LONG_CNT),
        .REPEAT_CNT (REPEAT_CNT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_level    (btn_level),
        .short_pulse  (short_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .held         (held),
        .long_active  (long_active)
    );

    assign obs = {short_pulse, long_pulse, repeat_pulse, held, long_active};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a level for the next edge, then let outputs settle 1 time unit after it.
    task automatic edge_step(input logic b);
        btn_level = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap();
        for (int i = 0; i < 3; i++) edge_step(1'b0);
    endtask

    task automatic test_reset();
        logic [4:0] exp;
        rst_n = 1'b0;
        btn_level = 1'b0;
        #12;
        checks++;
        if (obs !== 5'b00000) begin
            failures++;
            $display("FAIL reset_init obs=%b exp=%b", obs, 5'b00000);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        // Press into LONG (E0..E10), then hit reset mid-cycle while long_pulse is high.
        for (int k = 0; k <= LONG_CNT; k++) edge_step(1'b1);
        exp = 5'b01011;
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL reset_pre_long obs=%b exp=%b", obs, exp);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 5'b00000) begin
            failures++;
            $display("FAIL reset_async obs=%b exp=%b", obs, 5'b00000);
        end
        @(posedge clk); #1;
        checks++;
        if (obs !== 5'b00000) begin
            failures++;
            $display("FAIL reset_held_low obs=%b exp=%b", obs, 5'b00000);
        end
        #2;
        rst_n = 1'b1;
        // Button still down: first edge after deassertion is a fresh E0.
        edge_step(1'b1);
        exp = 5'b00010;
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL reset_fresh_press obs=%b exp=%b", obs, exp);
        end
        edge_step(1'b0);
        exp = 5'b10000;
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL reset_fresh_release obs=%b exp=%b", obs, exp);
        end
        idle_gap();
    endtask

    task automatic test_short_press();
        logic [4:0] exp;
        for (int k = 0; k <= 6; k++) begin
            edge_step(k <= 4);
            if (k <= 4)      exp = 5'b00010;
            else if (k == 5) exp = 5'b10000;
            else             exp = 5'b00000;
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL short_press E%0d obs=%b exp=%b", k, obs, exp);
            end
        end
        idle_gap();
    endtask

    task automatic test_threshold();
        logic [4:0] exp;
        // Release on E10: still a short press.
        for (int k = 0; k <= 11; k++) begin
            edge_step(k <= 9);
            if (k <= 9)       exp = 5'b00010;
            else if (k == 10) exp = 5'b10000;
            else              exp = 5'b00000;
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL thresh_short E%0d obs=%b exp=%b", k, obs, exp);
            end
        end
        idle_gap();
        // Held through E10: long press, silent release at E12.
        for (int k = 0; k <= 13; k++) begin
            edge_step(k <= 11);
            if (k <= 9)       exp = 5'b00010;
            else if (k == 10) exp = 5'b01011;
            else if (k == 11) exp = 5'b00011;
            else              exp = 5'b00000;
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL thresh_long E%0d obs=%b exp=%b", k, obs, exp);
            end
        end
        idle_gap();
    endtask

    task automatic test_repeat();
        logic [4:0] exp;
        logic       rep;
        for (int k = 0; k <= 32; k++) begin
            edge_step(k <= 30);
            rep = REP_EN && (k == 14 || k == 18 || k == 22 || k == 26 || k == 30);
            exp = {1'b0, (k == 10), rep, (k <= 30), (k >= 10 && k <= 30)};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL repeat E%0d obs=%b exp=%b", k, obs, exp);
            end
        end
        idle_gap();
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp;
        // Release at E5, re-press at E6 (new E0' = E6); long must land at E16.
        for (int k = 0; k <= 17; k++) begin
            edge_step(k != 5 && k <= 16);
            if (k <= 4)       exp = 5'b00010;
            else if (k == 5)  exp = 5'b10000;
            else if (k <= 15) exp = 5'b00010;
            else if (k == 16) exp = 5'b01011;
            else              exp = 5'b00000;
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL back_to_back E%0d obs=%b exp=%b", k, obs, exp);
            end
        end
        idle_gap();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        btn_level = 1'b0;
        test_reset();
        test_short_press();
        test_threshold();
        test_repeat();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
